// File: rtl/counter_ramp_ctrl.sv
// counter_ramp_ctrl: sequences an external loadable up/down counter through
// single or triangle ramps, holding the final value between commands.
module counter_ramp_ctrl #(
    parameter int CNT_WIDTH = 3,
    parameter int REP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CNT_WIDTH-1:0] start_val,
    input  logic [CNT_WIDTH-1:0] end_val,
    input  logic [REP_WIDTH-1:0] reps,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] counter_q,
    output logic                 load_en,
    output logic [CNT_WIDTH-1:0] counter_in,
    output logic                 up_down,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] start_r, end_r, tgt_r, hold_r;
    logic [REP_WIDTH-1:0] rem_r;
    logic                 dir_r, aborted_r;
    logic                 hit, last, accept;

    assign hit    = counter_q == tgt_r;
    assign last   = rem_r == '0;
    assign accept = start_valid && state == IDLE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_valid ? LOAD : IDLE;
            LOAD:    state_nxt = RUN;
            RUN:     state_nxt = (abort || (hit && last)) ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // The counter free-runs unless loaded, so every non-stepping cycle reloads a value.
    always_comb begin
        load_en    = 1'b1;
        counter_in = hold_r;
        up_down    = 1'b1;
        case (state)
            LOAD: begin
                counter_in = start_r;
                up_down    = dir_r;
            end
            RUN: begin
                counter_in = counter_q;
                up_down    = dir_r;
                if (!abort && !hit) load_en = 1'b0;
                else if (!abort && !last) begin
                    load_en = 1'b0;
                    up_down = ~dir_r;
                end
            end
            default: ;
        endcase
    end

    assign start_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign aborted     = done && aborted_r;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            start_r   <= '0;
            end_r     <= '0;
            tgt_r     <= '0;
            hold_r    <= '0;
            rem_r     <= '0;
            dir_r     <= 1'b1;
            aborted_r <= 1'b0;
        end else if (accept) begin
            start_r <= start_val;
            end_r   <= end_val;
            tgt_r   <= end_val;
            rem_r   <= reps;
            dir_r   <= end_val >= start_val;
        end else if (state == RUN) begin
            if (abort) begin
                hold_r    <= counter_q;
                aborted_r <= 1'b1;
            end else if (hit && last) hold_r <= counter_q;
            else if (hit) begin
                dir_r <= ~dir_r;
                tgt_r <= (tgt_r == end_r) ? start_r : end_r;
                rem_r <= rem_r - 1'b1;
            end
        end else if (state == DONE) aborted_r <= 1'b0;
endmodule
